// File: rtl/ram_unit_if.sv
// Thread-unit bus and boot byte stream for the RAM responder.
// The master side drives requests and boot bytes; the RAM unit is the slave.
interface ram_unit_if;
  typedef logic [1:0] unit_sel_t;

  unit_sel_t   unit_sel;
  logic [31:0] unit_ctrl;
  logic [31:0] unit_in [2];
  logic [31:0] unit_out;

  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        boot_done;

  modport master (
    output unit_sel, unit_ctrl, unit_in, load_valid, load_data, load_last,
    input  unit_out, load_ready, boot_done
  );

  modport slave (
    input  unit_sel, unit_ctrl, unit_in, load_valid, load_data, load_last,
    output unit_out, load_ready, boot_done
  );
endinterface

// File: rtl/ram_unit.sv
// Word memory serving thread fetches and loads/stores, filled after reset by a
// little-endian boot byte stream. unit_out is zero unless this unit is reading.
module ram_unit #(
  parameter int unsigned DEPTH = 1024
) (
  input logic     clk,
  input logic     rst,
  ram_unit_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [1:0]  UNIT_SEL_RAM   = 2'd2;
  localparam logic [31:0] RAM_CTRL_READ  = 32'd1;
  localparam logic [31:0] RAM_CTRL_WRITE = 32'd2;

  typedef enum logic {StLoad, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;

  logic [31:0] mem_q [DEPTH];

  logic              load_acc;
  logic              word_done;
  logic [31:0]       load_word;
  logic [ADDR_W-1:0] unit_idx;
  logic              ram_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              unused_addr;

  // Word aligned; upper address bits ignored so accesses wrap modulo DEPTH.
  assign unit_idx    = bus.unit_in[0][ADDR_W+1:2];
  assign unused_addr = ^{bus.unit_in[0][31:ADDR_W+2], bus.unit_in[0][1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      load_ptr_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    load_acc   = bus.load_valid && (state_q == StLoad);
    word_done  = load_acc && ((byte_cnt_q == 2'd3) || bus.load_last);

    // Bytes not yet received stay zero, giving the pad for a short last word.
    unique case (byte_cnt_q)
      2'd0:    load_word = {24'h0, bus.load_data};
      2'd1:    load_word = {16'h0, bus.load_data, shift_q[7:0]};
      2'd2:    load_word = {8'h0, bus.load_data, shift_q[15:0]};
      default: load_word = {bus.load_data, shift_q};
    endcase

    if (load_acc) begin
      if (word_done) begin
        load_ptr_d = load_ptr_q + 1'b1;
        byte_cnt_d = '0;
        shift_d    = '0;
        if (bus.load_last || (load_ptr_q == ADDR_W'(DEPTH - 1))) begin
          state_d = StRun;
        end
      end else begin
        shift_d[8*byte_cnt_q +: 8] = bus.load_data;
        byte_cnt_d                 = byte_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    bus.boot_done  = (state_q == StRun);
    bus.load_ready = (state_q == StLoad);
    ram_sel        = bus.boot_done && (bus.unit_sel == UNIT_SEL_RAM);
    bus.unit_out   = (ram_sel && (bus.unit_ctrl == RAM_CTRL_READ)) ? mem_q[unit_idx] : 32'h0;

    if (state_q == StLoad) begin
      mem_we    = word_done;
      mem_waddr = load_ptr_q;
      mem_wdata = load_word;
    end else begin
      mem_we    = ram_sel && (bus.unit_ctrl == RAM_CTRL_WRITE);
      mem_waddr = unit_idx;
      mem_wdata = bus.unit_in[1];
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end
endmodule
